// File: rtl/lc3b_mem_arbiter.sv
// lc3b_mem_arbiter: round-robin owner of the single physical-memory port shared by I-cache and D-cache.
// Define ARB_PERF_CNT_EN to add saturating grant/conflict counters.
module lc3b_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_sig,
    input  logic                  icache_read,
    input  logic [ADDR_WIDTH-1:0] icache_address,
    output logic [LINE_WIDTH-1:0] icache_rdata,
    output logic                  icache_resp,
    input  logic                  dcache_read,
    input  logic                  dcache_write,
    input  logic [ADDR_WIDTH-1:0] dcache_address,
    input  logic [LINE_WIDTH-1:0] dcache_wdata,
    output logic [LINE_WIDTH-1:0] dcache_rdata,
    output logic                  dcache_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic                  busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [15:0]           perf_igrant,
    output logic [15:0]           perf_dgrant,
    output logic [15:0]           perf_conflict
`endif
);
    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;  // 0 = I-cache, 1 = D-cache
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] rd_buf_i_q, rd_buf_i_d;
    logic [LINE_WIDTH-1:0] rd_buf_d_q, rd_buf_d_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  icache_resp_q, icache_resp_d;
    logic                  dcache_resp_q, dcache_resp_d;
    logic                  busy_q, busy_d;
    logic                  i_req, d_req, grant_i, grant_d, serving_d;

    always_comb begin
        i_req   = icache_read;
        d_req   = dcache_read | dcache_write;
        grant_i = (state_q == IDLE) && i_req && (!d_req || last_grant_q);
        grant_d = (state_q == IDLE) && d_req && (!i_req || !last_grant_q);
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = grant_i ? SERVE_I : grant_d ? SERVE_D : IDLE;
            SERVE_I: state_d = mem_resp ? RESP_I : SERVE_I;
            SERVE_D: state_d = mem_resp ? RESP_D : SERVE_D;
            default: state_d = IDLE;
        endcase
        last_grant_d  = grant_i ? 1'b0 : grant_d ? 1'b1 : last_grant_q;
        addr_d        = grant_i ? icache_address : grant_d ? dcache_address : addr_q;
        wdata_d       = grant_d ? dcache_wdata : wdata_q;
        we_d          = grant_i ? 1'b0 : grant_d ? dcache_write : we_q;
        rd_buf_i_d    = (state_q == SERVE_I && mem_resp) ? mem_rdata : rd_buf_i_q;
        rd_buf_d_d    = (state_q == SERVE_D && mem_resp && !we_q) ? mem_rdata : rd_buf_d_q;
        // Outputs are decoded from the next state so they appear registered.
        serving_d     = (state_d == SERVE_I) || (state_d == SERVE_D);
        mem_read_d    = serving_d && !we_d;
        mem_write_d   = serving_d && we_d;
        icache_resp_d = (state_d == RESP_I);
        dcache_resp_d = (state_d == RESP_D);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset_sig) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rd_buf_i_q    <= '0;
            rd_buf_d_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            icache_resp_q <= 1'b0;
            dcache_resp_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_buf_i_q    <= rd_buf_i_d;
            rd_buf_d_q    <= rd_buf_d_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            icache_resp_q <= icache_resp_d;
            dcache_resp_q <= dcache_resp_d;
            busy_q        <= busy_d;
        end
    end

    assign icache_rdata = rd_buf_i_q;
    assign dcache_rdata = rd_buf_d_q;
    assign icache_resp  = icache_resp_q;
    assign dcache_resp  = dcache_resp_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_address  = addr_q;
    assign mem_wdata    = wdata_q;
    assign busy         = busy_q;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_igrant_q, perf_igrant_d;
    logic [15:0] perf_dgrant_q, perf_dgrant_d;
    logic [15:0] perf_conflict_q, perf_conflict_d;
    logic        i_wait, d_wait;

    // A side waits when it requests but is neither being served nor granted now.
    always_comb begin
        i_wait          = i_req && state_q != SERVE_I && state_q != RESP_I && !grant_i;
        d_wait          = d_req && state_q != SERVE_D && state_q != RESP_D && !grant_d;
        perf_igrant_d   = perf_igrant_q + {15'd0, grant_i && perf_igrant_q != 16'hFFFF};
        perf_dgrant_d   = perf_dgrant_q + {15'd0, grant_d && perf_dgrant_q != 16'hFFFF};
        perf_conflict_d = perf_conflict_q + {15'd0, (i_wait || d_wait) && perf_conflict_q != 16'hFFFF};
    end

    always_ff @(posedge clk) begin
        if (reset_sig) begin
            perf_igrant_q   <= '0;
            perf_dgrant_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_igrant_q   <= perf_igrant_d;
            perf_dgrant_q   <= perf_dgrant_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_igrant   = perf_igrant_q;
    assign perf_dgrant   = perf_dgrant_q;
    assign perf_conflict = perf_conflict_q;
`endif
endmodule
